// File: rtl/rf_access_ctrl_pkg.sv
// Shared types and constants for the register-file access sequencer.
// Holds the state encoding and width defaults used by rf_access_ctrl.
package rf_access_ctrl_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_REGS   = 32;
    localparam int CNT_W      = 3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        OPND = 3'd2,
        WB   = 3'd3,
        FIN  = 3'd4
    } state_t;

endpackage

// File: rtl/rf_access_ctrl_lat_counter.sv
// Loadable down-counter with zero flag.
// Times how long the register-file read strobe is held.
module rf_lat_counter
    import rf_access_ctrl_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/rf_access_ctrl.sv
// Register-file access sequencer: read, operand hand-off, write-back.
// Build option: RF_ACCESS_ZERO_GUARD_EN makes register 0 read as 0 and ignore writes.
module rf_access_ctrl
    import rf_access_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W_DEF,
    parameter int ADDR_WIDTH = ADDR_W_DEF,
    parameter int RF_RD_LAT  = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic [ADDR_WIDTH-1:0] REQ_RS,
    input  logic [ADDR_WIDTH-1:0] REQ_RT,
    input  logic [ADDR_WIDTH-1:0] REQ_RD,
    input  logic                  REQ_WB,
    output logic                  OP_VALID,
    output logic [DATA_WIDTH-1:0] OP_A,
    output logic [DATA_WIDTH-1:0] OP_B,
    input  logic                  RES_VALID,
    input  logic [DATA_WIDTH-1:0] RES_DATA,
    output logic                  DONE,
    output logic                  RF_READ,
    output logic                  RF_WRITE,
    output logic [ADDR_WIDTH-1:0] RF_ADDR_R1,
    output logic [ADDR_WIDTH-1:0] RF_ADDR_R2,
    output logic [ADDR_WIDTH-1:0] RF_ADDR_W,
    output logic [DATA_WIDTH-1:0] RF_DATA_W,
    input  logic [DATA_WIDTH-1:0] RF_DATA_R1,
    input  logic [DATA_WIDTH-1:0] RF_DATA_R2
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RF_RD_LAT - 1);

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] rs_q, rt_q, rd_q;
    logic                  wb_q;
    logic [DATA_WIDTH-1:0] op_a_q, op_b_q, wdata_q;
    logic [DATA_WIDTH-1:0] opnd_a, opnd_b;
    logic                  wb_eff;
    logic                  cnt_load, cnt_dec, cnt_zero;

`ifdef RF_ACCESS_ZERO_GUARD_EN
    assign opnd_a = (rs_q == '0) ? '0 : RF_DATA_R1;
    assign opnd_b = (rt_q == '0) ? '0 : RF_DATA_R2;
    assign wb_eff = wb_q && (rd_q != '0);
`else
    assign opnd_a = RF_DATA_R1;
    assign opnd_b = RF_DATA_R2;
    assign wb_eff = wb_q;
`endif

    rf_lat_counter #(.W(CNT_W)) u_lat (
        .clk      (CLK),
        .rst      (RST),
        .load     (cnt_load),
        .load_val (LAT_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (REQ_VALID) begin
                    cnt_load = 1'b1;
                    state_d  = RD;
                end
            end
            RD: begin
                if (cnt_zero) begin
                    state_d = OPND;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            OPND: begin
                if (RES_VALID) begin
                    state_d = wb_eff ? WB : FIN;
                end
            end
            WB:      state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            wb_q    <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            wdata_q <= '0;
        end else begin
            if ((state_q == IDLE) && REQ_VALID) begin
                rs_q <= REQ_RS;
                rt_q <= REQ_RT;
                rd_q <= REQ_RD;
                wb_q <= REQ_WB;
            end
            if ((state_q == RD) && cnt_zero) begin
                op_a_q <= opnd_a;
                op_b_q <= opnd_b;
            end
            if ((state_q == OPND) && RES_VALID && wb_eff) begin
                wdata_q <= RES_DATA;
            end
        end
    end

    // Strobes are gated by RST so an aborted operation never leaks a write or DONE.
    assign REQ_READY  = !RST && (state_q == IDLE);
    assign RF_READ    = !RST && (state_q == RD);
    assign OP_VALID   = !RST && (state_q == OPND);
    assign RF_WRITE   = !RST && (state_q == WB);
    assign DONE       = !RST && (state_q == FIN);

    assign RF_ADDR_R1 = (state_q == RD) ? rs_q : '0;
    assign RF_ADDR_R2 = (state_q == RD) ? rt_q : '0;
    assign RF_ADDR_W  = (state_q == WB) ? rd_q : '0;
    assign RF_DATA_W  = (state_q == WB) ? wdata_q : '0;
    assign OP_A       = op_a_q;
    assign OP_B       = op_b_q;

endmodule
